// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction memory arbiter
package imem_pkg;

  localparam int IMEM_ADDR_W = 13;
  localparam int IMEM_DATA_W = 32;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Tags which requester owns the read data returning from the RAM next cycle.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DBG   = 2'd2
  } owner_e;

endpackage

// File: rtl/imem_prio_sel.sv
// rtl/imem_prio_sel.sv - combinational fetch/debug grant select from state and starvation flag
module imem_prio_sel
  import imem_pkg::*;
(
  input  logic   en_i,
  input  state_e state_i,
  input  logic   fetch_req_i,
  input  logic   dbg_req_i,
  input  logic   starve_i,
  output logic   fetch_sel_o,
  output logic   dbg_sel_o
);

  always_comb begin
    fetch_sel_o = 1'b0;
    dbg_sel_o   = 1'b0;
    if (en_i) begin
      if (state_i == BOOT) begin
        dbg_sel_o = dbg_req_i;
      end else if (fetch_req_i && dbg_req_i) begin
        // Fetch wins contention until debug has lost STARVE_MAX cycles in a row.
        dbg_sel_o   = starve_i;
        fetch_sel_o = !starve_i;
      end else begin
        fetch_sel_o = fetch_req_i;
        dbg_sel_o   = dbg_req_i;
      end
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - BOOT/RUN sequencer sharing the single-port instruction RAM
// Optional IMEM_WP_EN: debug writes in RUN are suppressed and flagged on dbg_err.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W     = IMEM_ADDR_W,
  parameter int DATA_W     = IMEM_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_valid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              boot_done,
  output logic              cpu_run,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef IMEM_WP_EN
  ,
  output logic              dbg_err
`endif
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] fetch_data_q, dbg_rdata_q;
  logic              wp_block;

  imem_prio_sel u_sel (
    .en_i        (rst_n),
    .state_i     (state_q),
    .fetch_req_i (fetch_req),
    .dbg_req_i   (dbg_req),
    .starve_i    (cnt_q == STARVE_LIM),
    .fetch_sel_o (fetch_gnt),
    .dbg_sel_o   (dbg_gnt)
  );

`ifdef IMEM_WP_EN
  logic err_q;
  assign wp_block = dbg_gnt && dbg_we && (state_q == RUN);
  assign dbg_err  = err_q && rst_n;
`else
  assign wp_block = 1'b0;
`endif

  always_comb begin
    mem_en    = (fetch_gnt || dbg_gnt) && !wp_block;
    mem_we    = dbg_gnt && dbg_we && !wp_block;
    mem_addr  = fetch_gnt ? fetch_addr : (dbg_gnt ? dbg_addr : '0);
    mem_wdata = (dbg_gnt && dbg_we) ? dbg_wdata : '0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    owner_d = OWN_NONE;
    if (state_q == BOOT && boot_done) begin
      state_d = RUN;
    end
    // Counter only grows while debug is actively losing to fetch.
    if (state_q == RUN && fetch_gnt && dbg_req) begin
      cnt_d = cnt_q + 4'd1;
    end
    if (fetch_gnt) begin
      owner_d = OWN_FETCH;
    end else if (dbg_gnt) begin
      owner_d = OWN_DBG;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      owner_q      <= OWN_NONE;
      cnt_q        <= '0;
      fetch_data_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      if (owner_q == OWN_FETCH) fetch_data_q <= mem_rdata;
      if (owner_q == OWN_DBG)   dbg_rdata_q  <= mem_rdata;
    end
  end

`ifdef IMEM_WP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= wp_block;
  end
`endif

  // RAM data arrives the cycle after grant; present it live, then hold the captured copy.
  assign fetch_valid = rst_n && (owner_q == OWN_FETCH);
  assign dbg_valid   = rst_n && (owner_q == OWN_DBG);
  assign fetch_data  = fetch_valid ? mem_rdata : fetch_data_q;
  assign dbg_rdata   = dbg_valid ? mem_rdata : dbg_rdata_q;
  assign cpu_run     = (state_q == RUN);

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed scoreboard bench for imem_arbiter with a RAM model
module tb_imem_arbiter;

  localparam int AW = 13;
  localparam int DW = 32;

  typedef struct {
    logic [DW-1:0] data;
    logic          rd;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_req, dbg_req, dbg_we, boot_done;
  logic [AW-1:0] fetch_addr, dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          fetch_gnt, fetch_valid, dbg_gnt, dbg_valid, cpu_run;
  logic [DW-1:0] fetch_data, dbg_rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
`ifdef IMEM_WP_EN
  logic          dbg_err;
`endif

  logic [DW-1:0] ram     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  exp_t          fq[$];
  exp_t          dq[$];
  exp_t          mon_e;
  int            n_cmp = 0;
  int            n_fail = 0;
  logic          in_run = 1'b0;

  always #5 clk = ~clk;

  imem_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_gnt   (fetch_gnt),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .dbg_req     (dbg_req),
    .dbg_we      (dbg_we),
    .dbg_addr    (dbg_addr),
    .dbg_wdata   (dbg_wdata),
    .dbg_gnt     (dbg_gnt),
    .dbg_valid   (dbg_valid),
    .dbg_rdata   (dbg_rdata),
    .boot_done   (boot_done),
    .cpu_run     (cpu_run),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
`ifdef IMEM_WP_EN
    ,
    .dbg_err     (dbg_err)
`endif
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("gnt_exclusive", {31'd0, fetch_gnt && dbg_gnt}, 32'd0);
    if (fetch_valid === 1'b1) begin
      if (fq.size() == 0) chk("fetch_valid_unexpected", 32'd1, 32'd0);
      else begin
        mon_e = fq.pop_front();
        chk("fetch_data", fetch_data, mon_e.data);
      end
    end
    if (dbg_valid === 1'b1) begin
      if (dq.size() == 0) chk("dbg_valid_unexpected", 32'd1, 32'd0);
      else begin
        mon_e = dq.pop_front();
        if (mon_e.rd) chk("dbg_rdata", dbg_rdata, mon_e.data);
`ifdef IMEM_WP_EN
        chk("dbg_err", {31'd0, dbg_err}, {31'd0, mon_e.err});
`endif
      end
    end
  end

  task automatic cyc(input logic fr, input int fa, input logic dr, input logic dwe, input int da,
                     input logic [DW-1:0] dwd, input logic bd, input logic efg, input logic edg,
                     input logic push);
    logic blk;
    exp_t e;
    fetch_req = fr; fetch_addr = AW'(fa);
    dbg_req = dr; dbg_we = dwe; dbg_addr = AW'(da); dbg_wdata = dwd;
    boot_done = bd;
    @(negedge clk);
    chk("fetch_gnt", {31'd0, fetch_gnt}, {31'd0, efg});
    chk("dbg_gnt", {31'd0, dbg_gnt}, {31'd0, edg});
    if (efg) begin
      chk("mem_addr_fetch", {19'd0, mem_addr}, fa);
      e.data = ref_mem[fa]; e.rd = 1'b1; e.err = 1'b0;
      if (push) fq.push_back(e);
    end
    if (edg) begin
      blk = 1'b0;
`ifdef IMEM_WP_EN
      blk = in_run && dwe;
`endif
      chk("mem_en_dbg", {31'd0, mem_en}, {31'd0, !blk});
      chk("mem_we_dbg", {31'd0, mem_we}, {31'd0, dwe && !blk});
      if (!blk) chk("mem_addr_dbg", {19'd0, mem_addr}, da);
      if (dwe && !blk) ref_mem[da] = dwd;
      e.data = ref_mem[da]; e.rd = !dwe; e.err = blk;
      if (push) dq.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cpu_run"}, {31'd0, cpu_run}, 32'd0);
    chk({tag, "_fetch_valid"}, {31'd0, fetch_valid}, 32'd0);
    chk({tag, "_dbg_valid"}, {31'd0, dbg_valid}, 32'd0);
    chk({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, {19'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_fetch_data"}, fetch_data, 32'd0);
    chk({tag, "_dbg_rdata"}, dbg_rdata, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; dbg_req = 1'b0; dbg_we = 1'b0;
    dbg_addr = '0; dbg_wdata = '0; boot_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Boot load with fetch requesting throughout.
    cyc(1, 1, 1, 1, 0, 32'h20080005, 0, 0, 1, 1);
    chk("boot_cpu_run", {31'd0, cpu_run}, 32'd0);
    cyc(1, 1, 1, 1, 1, 32'h20090003, 0, 0, 1, 1);
    chk("boot_cpu_run", {31'd0, cpu_run}, 32'd0);
    for (int i = 2; i < 8; i++) cyc(1, 1, 1, 1, i, 32'h10000000 + i, 0, 0, 1, 1);
    cyc(1, 1, 1, 1, 13'h1FFF, 32'hCAFEF00D, 0, 0, 1, 1);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("boot_cpu_run", {31'd0, cpu_run}, 32'd0);

    // boot_done with a concurrent debug write that completes in RUN.
    cyc(1, 1, 1, 1, 2, 32'h22222222, 1, 0, 1, 1);
    in_run = 1'b1;
    chk("run_cpu_run", {31'd0, cpu_run}, 32'd1);
    cyc(1, 1, 0, 0, 0, 0, 0, 1, 0, 1);

    // Streaming fetch 0..7.
    for (int i = 0; i < 8; i++) cyc(1, i, 0, 0, 0, 0, 0, 1, 0, 1);

    // Contention: F F F F D repeating, debug reading the top address.
    for (int k = 0; k < 10; k++)
      cyc(1, k % 8, 1, 0, 13'h1FFF, 0, 0, (k % 5) != 4, (k % 5) == 4, 1);

    // boot_done in RUN is ignored.
    cyc(1, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    chk("run_hold_cpu_run", {31'd0, cpu_run}, 32'd1);

    // Debug write in RUN, then read back.
    cyc(0, 0, 1, 1, 3, 32'hDEADBEEF, 0, 0, 1, 1);
    cyc(0, 0, 1, 0, 3, 0, 0, 0, 1, 1);
    cyc(0, 0, 1, 0, 13'h1FFF, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Reset in the cycle after a fetch grant drops the completion.
    cyc(1, 5, 0, 0, 0, 0, 0, 1, 0, 0);
    rst_n = 1'b0; fetch_req = 1'b0;
    @(negedge clk);
    chk("rst_drop_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_zero("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1; in_run = 1'b0;
    cyc(1, 2, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("midrst_boot_cpu_run", {31'd0, cpu_run}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    chk("fetch_queue_drained", fq.size(), 32'd0);
    chk("dbg_queue_drained", dq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Sequences and shares the single-port 8192x32 instruction memory between two requesters: the CPU fetch stage and a debug/boot-loader port.
- After reset it stays in BOOT, where only the loader may access memory and program words are written in. It then switches to RUN, where fetch has priority and a bounded starvation counter guarantees debug access.
- Sits between the fetch stage and the instruction RAM; owns the RAM's only port.

Parameters:
- ADDR_W, 13, word-address width (depth = 2**ADDR_W).
- DATA_W, 32, instruction word width.
- STARVE_MAX, 4, consecutive RUN cycles debug may lose before it is forced a grant; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- fetch_req  in  1  fetch read request.
- fetch_addr  in  ADDR_W  fetch word address.
- fetch_gnt  out  1  fetch request accepted this cycle.
- fetch_valid  out  1  fetch_data valid (one cycle after fetch_gnt).
- fetch_data  out  DATA_W  fetched instruction.
- dbg_req  in  1  debug/loader request.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  ADDR_W  debug word address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_gnt  out  1  debug request accepted this cycle.
- dbg_valid  out  1  debug completion (one cycle after dbg_gnt, reads and writes).
- dbg_rdata  out  DATA_W  debug read data.
- boot_done  in  1  loader finished; request RUN.
- cpu_run  out  1  high in RUN; CPU holds its PC while low.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, registered, valid the cycle after mem_en.

Behaviour:
- Reset (rst_n low at a clk edge): state=BOOT, starvation counter=0.
  - All outputs 0: cpu_run, gnt/valid, mem_en/mem_we, data/address buses.
  - An in-flight completion is dropped; no valid pulses after reset.
- Clock and reset: one clock domain; rst_n is sampled only at the clk edge.
- Grant is combinational from req and state.
  - At most one of fetch_gnt and dbg_gnt is high per cycle.
  - mem_* are driven combinationally from the granted requester's signals.
- Latency: a *_gnt in cycle N gives *_valid=1 in cycle N+1, for exactly one cycle.
  - fetch_data/dbg_rdata are registered copies of mem_rdata, held until the next valid.
  - Back-to-back grants give back-to-back valids (throughput 1 access/cycle).
- BOOT state:
  - fetch_gnt=0 always; dbg_gnt=dbg_req.
  - boot_done=1 gives RUN next cycle; cpu_run rises that same next cycle.
  - A debug grant issued in the boot_done cycle completes normally in RUN.
- RUN state:
  - fetch_req alone wins; dbg_req alone wins.
  - If both request and counter<STARVE_MAX: fetch wins and the counter increments.
  - If both request and counter==STARVE_MAX: dbg wins.
  - Counter clears whenever dbg is granted or dbg_req=0.
- RUN is left only by reset; boot_done is ignored in RUN.
- Addresses are word addresses and are passed through unmodified; no wrap or range check.
- Requesters must hold req/addr/wdata stable until their gnt.

Optional Feature:
- IMEM_WP_EN defined: debug writes in RUN are still granted, but mem_we=0 and mem_en=0 for that access.
  - dbg_valid still pulses, and dbg_err (extra output, 1 bit) pulses with it.
  - dbg_err resets to 0.
- IMEM_WP_EN undefined: debug writes in RUN are performed normally; the dbg_err port does not exist.

Decomposition:
- Shared package imem_pkg:
  - State enum {BOOT, RUN}.
  - IMEM_ADDR_W=13 and IMEM_DATA_W=32 constants.
  - Owner enum {OWN_NONE, OWN_FETCH, OWN_DBG} for the in-flight return tag.
- Sub-module imem_prio_sel: combinational fetch/debug select given state and starvation flag.
  - The FSM, counter and return-data registers stay in imem_arbiter.

Test Plan:
- Boot load: write 0x20080005 to addr 0 and 0x20090003 to addr 1 in BOOT, with fetch_req=1 throughout.
  - Expect fetch_gnt=0 throughout, two dbg_valid pulses, cpu_run=0.
  - Then boot_done=1: cpu_run=1 next cycle; a fetch of addr 1 returns 0x20090003 one cycle after grant.
- Streaming fetch: fetch_req=1 with addr 0..7 incrementing each cycle.
  - Expect eight consecutive fetch_valid cycles with data matching the loaded words, one-cycle lag.
- Starvation: fetch_req and dbg_req held 1 in RUN, STARVE_MAX=4.
  - Expect 4 fetch grants, 1 dbg grant, repeating (pattern F F F F D).
- Reset mid-operation: rst_n=0 in the cycle after a fetch grant.
  - Expect fetch_valid=0, state BOOT, cpu_run=0, all outputs 0.
- Boundary: debug read of addr 0x1FFF returns the value written there.
  - boot_done pulsed in RUN has no effect.
- IMEM_WP_EN build: debug write of 0xDEADBEEF to addr 3 in RUN.
  - Expect mem_we=0, dbg_valid=1 with dbg_err=1; a later read of addr 3 returns the old word.
